// File: rtl/dbl_dabble_seq.sv
// -----------------------------------------------------------------------------
// dbl_dabble_seq
//
// Sequential binary-to-BCD converter. Runs the double-dabble shift/add-3
// algorithm one bit per clock, so a W-bit value takes W RUN cycles. This trades
// latency for area compared with a fully combinational converter.
//
// Parameters
//   W          binary input width (4..13); also the iteration count
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      request conversion of b; only honoured while idle
//   b          binary value, captured on the accepted start edge
//   busy       high while a conversion is in progress (from the state register)
//   done       one-cycle registered pulse when new digits are valid
//   thousands  BCD thousands digit
//   hundreds   BCD hundreds digit
//   tens       BCD tens digit
//   ones       BCD ones digit
// -----------------------------------------------------------------------------
module dbl_dabble_seq #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [3:0]   thousands,
    output logic [3:0]   hundreds,
    output logic [3:0]   tens,
    output logic [3:0]   ones
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;

    // {bcd[15:0], bin[W-1:0]} working register.
    logic [W+15:0] sr;
    logic [3:0]    cnt;

    logic [15:0]   bcd_adj;
    logic [W+15:0] sr_pre;
    logic [W+15:0] sr_shift;
    logic          last;

    // Nibble correction: a 4-bit add with no carry out. A nibble >= 5 becomes
    // at most 12, so nothing is lost.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // One double-dabble iteration: add-3 to all four nibbles, then shift left.
    always_comb begin
        bcd_adj  = {add3(sr[W+15:W+12]), add3(sr[W+11:W+8]),
                    add3(sr[W+7:W+4]),   add3(sr[W+3:W])};
        sr_pre   = {bcd_adj, sr[W-1:0]};
        sr_shift = sr_pre << 1;
        last     = (cnt == 4'(W - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assigning the default before the case means every path writes
        // state_nxt, so no latch is inferred when a branch leaves it untouched.
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // An aborted conversion clears the digits too; no partial result
            // ever reaches the outputs.
            sr        <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            thousands <= '0;
            hundreds  <= '0;
            tens      <= '0;
            ones      <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, independent of statement order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr  <= {16'b0, b};
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sr  <= sr_shift;
                    cnt <= cnt + 4'd1;
                    if (last) begin
                        thousands <= sr_shift[W+15:W+12];
                        hundreds  <= sr_shift[W+11:W+8];
                        tens      <= sr_shift[W+7:W+4];
                        ones      <= sr_shift[W+3:W];
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_dbl_dabble_seq.sv
// -----------------------------------------------------------------------------
// tb_dbl_dabble_seq
//
// Self-checking bench for dbl_dabble_seq. Expected digits come from decimal
// arithmetic on the input value (v/1000, v/100%10, v/10%10, v%10). Directed
// cases cover the handshake corner cases; a random batch covers the range.
// -----------------------------------------------------------------------------
module tb_dbl_dabble_seq;

    localparam int W        = 13;
    localparam int MAX_WAIT = 60;
    localparam int N_RAND   = 600;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [3:0]   thousands;
    logic [3:0]   hundreds;
    logic [3:0]   tens;
    logic [3:0]   ones;

    int n_checks = 0;
    int n_fail   = 0;
    logic done_prev = 1'b0;

    dbl_dabble_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference: decimal digits packed as four BCD nibbles.
    function automatic int ref_bcd(input int v);
        return ((v / 1000) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int dut_bcd();
        return int'({thousands, hundreds, tens, ones});
    endfunction

    // Invariants watched on every cycle outside reset.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            check("busy_with_done", int'(busy), 0);
            check("done_width", int'(done_prev), 0);
        end
        done_prev <= done;
    end

    // Wait (at negedges) until done is seen; returns cycles waited and the
    // number of those cycles with busy high. Expired bound counts as a failure.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < MAX_WAIT) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    // Full conversion with a one-cycle start pulse; b scrambled afterwards.
    task automatic convert(input string tag, input int v);
        int cyc;
        int bc;
        @(negedge clk);
        start = 1'b1;
        b     = W'(v);
        @(negedge clk);
        start = 1'b0;
        b     = W'($urandom);
        wait_done(cyc, bc);
        check({tag, "_latency"}, cyc, W);
        check({tag, "_busy_cycles"}, bc, W);
        check({tag, "_digits"}, dut_bcd(), ref_bcd(v));
    endtask

    // Counts done pulses over n cycles; used where none must appear.
    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
    endtask

    initial begin
        int cyc;
        int bc;
        int pulses;
        int v;

        rst   = 1'b1;
        start = 1'b0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_digits", dut_bcd(), 0);
        rst = 1'b0;

        // Basic values and boundaries.
        convert("b1023", 1023);
        convert("b123",  123);
        convert("b1049", 1049);
        convert("b0",    0);
        convert("b8191", 8191);
        convert("b4095", 4095);
        convert("b8000", 8000);

        // Start while busy is ignored; b changes have no effect in flight.
        @(negedge clk);
        start = 1'b1;
        b     = W'(3000);
        @(negedge clk);
        start = 1'b0;
        b     = W'(1111);
        repeat (4) @(negedge clk);
        start = 1'b1;
        b     = W'(7777);
        @(negedge clk);
        start = 1'b0;
        b     = W'(5555);
        wait_done(cyc, bc);
        check("ignore_latency", cyc + 5, W);
        check("ignore_digits", dut_bcd(), ref_bcd(3000));
        count_done(2 * W, pulses);
        check("ignore_no_second_done", pulses, 0);

        // Start held high: back-to-back conversions, b switched in done cycle.
        @(negedge clk);
        start = 1'b1;
        b     = W'(9);
        @(negedge clk);
        wait_done(cyc, bc);
        check("held_first_digits", dut_bcd(), ref_bcd(9));
        b = W'(42);
        @(negedge clk);
        check("held_busy_after_done", int'(busy), 1);
        check("held_digits_kept", dut_bcd(), ref_bcd(9));
        wait_done(cyc, bc);
        check("held_done_spacing", cyc + 1, W + 1);
        check("held_second_digits", dut_bcd(), ref_bcd(42));
        start = 1'b0;
        @(negedge clk);
        check("held_released_busy", int'(busy), 0);

        // Reset mid-conversion aborts without writing a result.
        @(negedge clk);
        start = 1'b1;
        b     = W'(1234);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_digits", dut_bcd(), 0);
        count_done(2 * W, pulses);
        check("abort_no_done", pulses, 0);
        convert("after_abort_b56", 56);

        // Random values across the full range.
        for (int i = 0; i < N_RAND; i++) begin
            v = int'($urandom_range(0, (1 << W) - 1));
            convert("rand", v);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
